// File: rtl/dmem_responder.sv
// dmem_responder
//   Data-memory responder for the single-cycle MIPS core's data port. It holds a
//   DEPTH x 32 word array and services one load or store per request. Each access
//   takes LAT cycles from capture to completion. The core is stalled for the whole
//   access except the completion cycle, so one access occupies LAT+1 cycles.
//
// Parameters
//   AW   word-address width, DEPTH = 2**AW
//   LAT  access latency in cycles (1..15)
//
// Ports
//   clk          clock, rising edge
//   rst          asynchronous reset, active-high
//   CEN/WEN/OEN  chip / write / output enable, all active-low
//   A            word address
//   Data2Mem     store data
//   ReadDataMem  load data; holds the last load result
//   stall        core must hold PC and request while high
//   ack          one-cycle pulse on the completion (DONE) cycle
//   err          one-cycle pulse on a conflicting request (WEN and OEN both low)
module dmem_responder #(
  parameter int AW  = 7,
  parameter int LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          CEN,
  input  logic          WEN,
  input  logic          OEN,
  input  logic [AW-1:0] A,
  input  logic [31:0]   Data2Mem,
  output logic [31:0]   ReadDataMem,
  output logic          stall,
  output logic          ack,
  output logic          err
);

  localparam int         DEPTH    = 1 << AW;
  localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state, state_nxt;
  logic [3:0]    cnt, cnt_nxt;
  logic [AW-1:0] addr_q;
  logic [31:0]   data_q;
  logic          wr_q;
  logic [31:0]   mem [DEPTH];

  logic          req_rd, req_wr, req_conf;
  logic          capture, finish;
  logic [AW-1:0] acc_addr;
  logic [31:0]   acc_data;
  logic          acc_wr;

  always_comb begin
    req_rd   = !CEN && !OEN &&  WEN;
    req_wr   = !CEN && !WEN &&  OEN;
    req_conf = !CEN && !WEN && !OEN;
  end

  // finish marks the edge that enters DONE: the array write or load happens there.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    capture   = 1'b0;
    finish    = 1'b0;
    stall     = 1'b0;
    ack       = 1'b0;
    err       = 1'b0;
    case (state)
      IDLE: begin
        if (req_rd || req_wr) begin
          capture = 1'b1;
          stall   = 1'b1;
          cnt_nxt = CNT_INIT;
          if (LAT == 1) begin
            state_nxt = DONE;
            finish    = 1'b1;
          end else begin
            state_nxt = BUSY;
          end
        end else if (req_conf) begin
          err = 1'b1;
        end
      end
      BUSY: begin
        stall   = 1'b1;
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) begin
          state_nxt = DONE;
          finish    = 1'b1;
        end
      end
      DONE: begin
        ack       = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // With LAT==1 the access completes on the capture edge, so the live inputs are
  // used; otherwise the values captured in IDLE are used and later input changes
  // have no effect.
  always_comb begin
    acc_addr = capture ? A        : addr_q;
    acc_data = capture ? Data2Mem : data_q;
    acc_wr   = capture ? req_wr   : wr_q;
  end

  // ---- control state ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      ReadDataMem <= 32'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (finish && !acc_wr) ReadDataMem <= mem[acc_addr];
    end
  end

  // ---- request capture ----
  always_ff @(posedge clk) begin
    if (capture) begin
      addr_q <= A;
      data_q <= Data2Mem;
      wr_q   <= req_wr;
    end
  end

  // ---- array write; a reset before DONE drops the pending store ----
  always_ff @(posedge clk) begin
    if (finish && acc_wr && !rst) mem[acc_addr] <= acc_data;
  end

endmodule
